// File: rtl/aircon_mode_ctrl.sv
// Aircon mode controller: button sync/debounce, 5-state mode FSM, turbo timer and
// compressor guard. Optional idle auto-off is enabled by defining AIRCON_AUTO_OFF_EN.
module aircon_mode_ctrl #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned TURBO_CYCLES = 16,
    parameter int unsigned COMP_GUARD   = 8,
    parameter int unsigned IDLE_CYCLES  = 64
) (
    input  logic       Clk,
    input  logic       Rst_N,
    input  logic       Up_Btn_In,
    input  logic       Dn_Btn_In,
    input  logic       Off_Btn_In,
    input  logic       Turbo_Btn_In,
    output logic [3:0] Thermo_Out,
    output logic       Turbo_Out,
    output logic       Guard_Out
);

    // Encodings equal the display codes, so the outputs come straight from flops.
    typedef enum logic [3:0] {
        StOff      = 4'b0000,
        StLowFan   = 4'b0001,
        StHighFan  = 4'b0010,
        StLowCool  = 4'b0100,
        StHighCool = 4'b1000
    } state_e;

    localparam logic [7:0] DebMax   = 8'(DEB_CYCLES);
    localparam logic [7:0] TurboMax = 8'(TURBO_CYCLES);
    localparam logic [7:0] GuardMax = 8'(COMP_GUARD);

    function automatic logic is_cool(input state_e s);
        return (s == StLowCool) || (s == StHighCool);
    endfunction

    // Button index: 0 up, 1 down, 2 off, 3 turbo.
    logic [3:0]      raw;
    logic [3:0]      sync1_q, sync2_q, ev_q;
    logic [3:0][7:0] deb_q;

    assign raw = {Turbo_Btn_In, Off_Btn_In, Dn_Btn_In, Up_Btn_In};

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ev_q    <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                // Pulse on the edge the counter reaches DebMax; it then saturates.
                ev_q[i] <= sync2_q[i] && (deb_q[i] == DebMax - 8'd1);
                if (!sync2_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] != DebMax) begin
                    deb_q[i] <= deb_q[i] + 8'd1;
                end
            end
        end
    end

    logic up_ev, dn_ev, off_ev, turbo_ev;
    assign up_ev    = ev_q[0];
    assign dn_ev    = ev_q[1];
    assign off_ev   = ev_q[2];
    assign turbo_ev = ev_q[3];

    state_e     state_q, state_d;
    logic       turbo_q, turbo_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] guard_q, guard_d;
    logic       guard_on_q;
    logic       go_off;

`ifdef AIRCON_AUTO_OFF_EN
    localparam logic [15:0] IdleMax = 16'(IDLE_CYCLES);
    logic [15:0] idle_q, idle_d;
    logic        any_ev;
`else
    logic [15:0] unused_idle;
    assign unused_idle = 16'(IDLE_CYCLES);
`endif

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q    <= StOff;
            turbo_q    <= 1'b0;
            tcnt_q     <= '0;
            guard_q    <= '0;
            guard_on_q <= 1'b0;
`ifdef AIRCON_AUTO_OFF_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            turbo_q    <= turbo_d;
            tcnt_q     <= tcnt_d;
            guard_q    <= guard_d;
            guard_on_q <= (guard_d != 8'd0);
`ifdef AIRCON_AUTO_OFF_EN
            idle_q     <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        turbo_d = turbo_q;
        tcnt_d  = tcnt_q;
        guard_d = guard_q;
        go_off  = off_ev;
`ifdef AIRCON_AUTO_OFF_EN
        any_ev = |ev_q;
        idle_d = idle_q;
        if (state_q != StOff && idle_q != 16'd0) idle_d = idle_q - 16'd1;
        // Entering a non-OFF state always needs an event, so this also covers entry reload.
        if (any_ev) idle_d = IdleMax;
        if (!any_ev && state_q != StOff && idle_q <= 16'd1) go_off = 1'b1;
`endif
        if (guard_q != 8'd0) guard_d = guard_q - 8'd1;
        if (turbo_q) begin
            if (tcnt_q <= 8'd1) begin
                turbo_d = 1'b0;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q - 8'd1;
            end
        end

        if (go_off) begin
            state_d = StOff;
        end else if (up_ev ^ dn_ev) begin
            if (up_ev) begin
                unique case (state_q)
                    StOff:     state_d = StLowFan;
                    StLowFan:  state_d = StHighFan;
                    StHighFan: if (guard_q == 8'd0) state_d = StLowCool;
                    StLowCool: state_d = StHighCool;
                    default:   state_d = state_q;
                endcase
            end else begin
                unique case (state_q)
                    StHighCool: state_d = StLowCool;
                    StLowCool:  state_d = StHighFan;
                    StHighFan:  state_d = StLowFan;
                    StLowFan:   state_d = StOff;
                    default:    state_d = state_q;
                endcase
            end
        end

        if (state_d == StOff) begin
            turbo_d = 1'b0;
            tcnt_d  = '0;
        end else if (turbo_ev) begin
            turbo_d = !turbo_q;
            tcnt_d  = turbo_q ? 8'd0 : TurboMax;
        end

        if (is_cool(state_q) && !is_cool(state_d)) guard_d = GuardMax;
    end

    always_comb begin
        Thermo_Out = state_q;
        Turbo_Out  = turbo_q;
        Guard_Out  = guard_on_q;
    end

endmodule

// File: tb/tb_aircon_mode_ctrl.sv
// Directed bench for aircon_mode_ctrl: press table plus hand-written timing sequences.
module tb_aircon_mode_ctrl;

    logic       Clk   = 1'b0;
    logic       Rst_N = 1'b1;
    logic       up    = 1'b0;
    logic       dn    = 1'b0;
    logic       off   = 1'b0;
    logic       turbo = 1'b0;
    logic [3:0] thermo;
    logic       turbo_o;
    logic       guard_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    aircon_mode_ctrl #(
        .DEB_CYCLES  (4),
        .TURBO_CYCLES(16),
        .COMP_GUARD  (8),
        .IDLE_CYCLES (20)
    ) dut (
        .Clk         (Clk),
        .Rst_N       (Rst_N),
        .Up_Btn_In   (up),
        .Dn_Btn_In   (dn),
        .Off_Btn_In  (off),
        .Turbo_Btn_In(turbo),
        .Thermo_Out  (thermo),
        .Turbo_Out   (turbo_o),
        .Guard_Out   (guard_o)
    );

    // btn = {up, dn, off, turbo}
    typedef struct packed {
        logic [3:0] btn;
        logic [3:0] thermo;
        logic       turbo;
        logic       guard;
    } vec_t;

    vec_t vecs [17];

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] t, input logic tb,
                             input logic g);
        check4({name, ".thermo"}, thermo, t);
        check1({name, ".turbo"}, turbo_o, tb);
        check1({name, ".guard"}, guard_o, g);
    endtask

    task automatic set_btn(input logic [3:0] m);
        {up, dn, off, turbo} = m;
    endtask

    // Called 1 time unit after a rising edge; returns aligned the same way.
    task automatic do_reset();
        #2;
        Rst_N = 1'b0;
        set_btn(4'b0000);
        #1;
        check_all("reset", 4'b0000, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        Rst_N = 1'b1;
    endtask

    task automatic press(input logic [3:0] m);
        set_btn(m);
        repeat (7) @(posedge Clk);
        #1;
    endtask

    task automatic release_all();
        set_btn(4'b0000);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic tap(input logic [3:0] m);
        press(m);
        release_all();
    endtask

    task automatic up_latency(input string name);
        logic [3:0] exp;
        set_btn(4'b1000);
        for (int k = 1; k <= 10; k++) begin
            @(posedge Clk);
            #1;
            exp = (k < 7) ? 4'b0000 : 4'b0001;
            check4(name, thermo, exp);
        end
        check1({name, ".turbo"}, turbo_o, 1'b0);
        check1({name, ".guard"}, guard_o, 1'b0);
        release_all();
    endtask

    initial begin
        vecs[0]  = '{4'b1000, 4'b0001, 1'b0, 1'b0};
        vecs[1]  = '{4'b1000, 4'b0010, 1'b0, 1'b0};
        vecs[2]  = '{4'b1000, 4'b0100, 1'b0, 1'b0};
        vecs[3]  = '{4'b1000, 4'b1000, 1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 4'b1000, 1'b0, 1'b0};
        vecs[5]  = '{4'b0100, 4'b0100, 1'b0, 1'b0};
        vecs[6]  = '{4'b1000, 4'b1000, 1'b0, 1'b0};
        vecs[7]  = '{4'b0001, 4'b1000, 1'b1, 1'b0};
        vecs[8]  = '{4'b0001, 4'b1000, 1'b0, 1'b0};
        vecs[9]  = '{4'b0100, 4'b0100, 1'b0, 1'b0};
        vecs[10] = '{4'b0100, 4'b0010, 1'b0, 1'b1};
        vecs[11] = '{4'b1100, 4'b0010, 1'b0, 1'b0};
        vecs[12] = '{4'b0010, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{4'b0001, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{4'b1000, 4'b0001, 1'b0, 1'b0};
        vecs[15] = '{4'b0001, 4'b0001, 1'b1, 1'b0};
        vecs[16] = '{4'b0011, 4'b0000, 1'b0, 1'b0};

        do_reset();
        up_latency("latency");

        do_reset();
        for (int i = 0; i < 17; i++) begin
            press(vecs[i].btn);
            check_all($sformatf("vec%0d", i), vecs[i].thermo, vecs[i].turbo, vecs[i].guard);
            release_all();
        end

        // Guard window: an Up landing 7 edges after leaving cool must be dropped.
        do_reset();
        repeat (4) tap(4'b1000);
        press(4'b0100);
        check_all("grd_lowcool", 4'b0100, 1'b0, 1'b0);
        release_all();
        press(4'b0100);
        check_all("grd_enter", 4'b0010, 1'b0, 1'b1);
        set_btn(4'b1000);
        for (int k = 1; k <= 8; k++) begin
            @(posedge Clk);
            #1;
            check1($sformatf("grd_flag%0d", k), guard_o, (k < 8) ? 1'b1 : 1'b0);
            if (k == 7) check4("grd_block", thermo, 4'b0010);
        end
        release_all();
        press(4'b1000);
        check_all("grd_after", 4'b0100, 1'b0, 1'b0);
        release_all();

        // Turbo auto-expiry after exactly 16 edges.
        do_reset();
        tap(4'b1000);
        press(4'b0001);
        check_all("trb_on", 4'b0001, 1'b1, 1'b0);
        set_btn(4'b0000);
        for (int k = 1; k <= 16; k++) begin
            @(posedge Clk);
            #1;
            check1($sformatf("trb_edge%0d", k), turbo_o, (k < 16) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset mid-debounce in HIGH_COOL with turbo on.
        do_reset();
        repeat (4) tap(4'b1000);
        press(4'b0001);
        check_all("rst_pre", 4'b1000, 1'b1, 1'b0);
        release_all();
        set_btn(4'b1000);
        repeat (3) @(posedge Clk);
        #1;
        do_reset();
        up_latency("rst_post");

        // Idle auto-off (macro build) or indefinite hold (default build).
        do_reset();
        repeat (2) tap(4'b1000);
        press(4'b1000);
        check_all("idle_enter", 4'b0100, 1'b0, 1'b0);
        release_all();
`ifdef AIRCON_AUTO_OFF_EN
        repeat (16) @(posedge Clk);
        #1;
        check_all("idle_before", 4'b0100, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        check_all("idle_off", 4'b0000, 1'b0, 1'b1);
`else
        repeat (197) @(posedge Clk);
        #1;
        check_all("idle_hold", 4'b0100, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
